clk_enable_gen: RTL and testbench

Parametrised, runtime-programmable multi-channel clock-enable generator. It replaces fixed PLL output frequencies for slow peripheral domains. From a single system clock it derives CHANNELS independent fractional-rate enable pulses and 50 % divided strobes using phase accumulators (NCOs), plus a lock indication. It sits beside the PLL wrapper and feeds video, audio and slave-controller logic that runs on clock enables instead of extra clock nets.

---
 rtl/clk_enable_pkg.sv | 18 +
 rtl/clk_enable_nco.sv | 62 ++++++
 rtl/clk_enable_gen.sv | 77 +++++++
 tb/tb_clk_enable_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_enable_pkg.sv
// rtl/clk_enable_pkg.sv - shared constants and increment helper for the clock-enable generator
package clk_enable_pkg;

    localparam int ACC_W_DEF  = 32;
    localparam int LOCK_CNT_W = 16;

    // Rounded NCO increment for f_out from f_clk: round(f_out * 2^acc_w / f_clk).
    function automatic logic [31:0] inc_for(
        input longint unsigned f_clk_hz,
        input longint unsigned f_out_hz,
        input int unsigned     acc_w
    );
        longint unsigned num;
        num = (f_out_hz << acc_w) + (f_clk_hz >> 1);
        return 32'(num / f_clk_hz);
    endfunction

endpackage

// File: rtl/clk_enable_nco.sv
// rtl/clk_enable_nco.sv - one phase-accumulator channel producing ce and a divided strobe
module clk_enable_nco
    import clk_enable_pkg::*;
#(
    parameter int               ACC_W   = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             sync,
    input  logic             we,
    input  logic [ACC_W-1:0] inc_in,
    output logic             ce,
    output logic             div_clk
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             ce_q, ce_d;
    logic             div_q, div_d;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    always_comb begin
        acc_d = acc_q;
        inc_d = inc_q;
        ce_d  = 1'b0;
        div_d = div_q;
        // Realignment wins over accumulation so every channel restarts from phase zero.
        if (sync) begin
            acc_d = '0;
            div_d = 1'b0;
        end else if (run) begin
            acc_d = sum[ACC_W-1:0];
            ce_d  = sum[ACC_W];
            div_d = div_q ^ sum[ACC_W];
        end
        if (we) begin
            inc_d = inc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            inc_q <= INC_RST;
            ce_q  <= 1'b0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            inc_q <= inc_d;
            ce_q  <= ce_d;
            div_q <= div_d;
        end
    end

    assign ce      = ce_q;
    assign div_clk = div_q;

endmodule

// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - multi-channel programmable clock-enable generator with lock indication
module clk_enable_gen
    import clk_enable_pkg::*;
#(
    parameter int                        CHANNELS    = 3,
    parameter int                        ACC_W       = ACC_W_DEF,
    parameter logic [CHANNELS*ACC_W-1:0] INC_INIT    = '0,
    parameter int unsigned               LOCK_CYCLES = 16
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           run,
    input  logic                                           cfg_we,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]                               cfg_inc,
    input  logic                                           cfg_sync,
    output logic [CHANNELS-1:0]                            ce,
    output logic [CHANNELS-1:0]                            div_clk,
    output logic                                           locked
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] we_ch;

    // Out-of-range channel indices match no decode term, so such writes are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign we_ch[i] = cfg_we && (cfg_ch == CH_W'(i));

        clk_enable_nco #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_INIT[i*ACC_W +: ACC_W])
        ) u_nco (
            .clk     (clk),
            .rst_n   (rst_n),
            .run     (run),
            .sync    (cfg_sync),
            .we      (we_ch[i]),
            .inc_in  (cfg_inc),
            .ce      (ce[i]),
            .div_clk (div_clk[i])
        );
    end

    logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
    logic                  locked_q, locked_d;
    logic                  lock_clr;

    assign lock_clr = cfg_we | cfg_sync | ~run;

    always_comb begin
        cnt_d    = cnt_q;
        locked_d = locked_q;
        if (lock_clr) begin
            cnt_d    = '0;
            locked_d = 1'b0;
        end else begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            locked_d = (cnt_q >= LOCK_CNT_W'(LOCK_CYCLES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb/tb_clk_enable_gen.sv - randomized self-checking bench for clk_enable_gen
module tb_clk_enable_gen;
    import clk_enable_pkg::*;

    localparam int      CH  = 3;
    localparam int      AW  = 16;
    localparam int      LC  = 16;
    localparam longint  MOD = 65536;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [AW-1:0] cfg_inc = '0;
    logic          cfg_sync = 1'b0;
    logic [CH-1:0] ce;
    logic [CH-1:0] div_clk;
    logic          locked;

    always #5 clk = ~clk;

    clk_enable_gen #(
        .CHANNELS    (CH),
        .ACC_W       (AW),
        .INC_INIT    ({16'h0000, 16'h4000, 16'h8000}),
        .LOCK_CYCLES (LC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_inc  (cfg_inc),
        .cfg_sync (cfg_sync),
        .ce       (ce),
        .div_clk  (div_clk),
        .locked   (locked)
    );

    int n_checks = 0;
    int n_fail   = 0;

    longint m_acc[CH];
    longint m_inc[CH];
    bit     m_ce[CH];
    bit     m_div[CH];
    int     m_since;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_acc[i] = 0;
            m_ce[i]  = 0;
            m_div[i] = 0;
        end
        m_inc[0] = 64'h8000;
        m_inc[1] = 64'h4000;
        m_inc[2] = 0;
        m_since  = 0;
    endtask

    // Reference behaviour: phase advances by inc modulo 2^AW, each wrap is one ce pulse.
    task automatic model_edge();
        longint s;
        for (int i = 0; i < CH; i++) begin
            if (cfg_sync) begin
                m_acc[i] = 0;
                m_ce[i]  = 0;
                m_div[i] = 0;
            end else if (run) begin
                s        = m_acc[i] + m_inc[i];
                m_ce[i]  = (s >= MOD);
                m_acc[i] = s % MOD;
                if (m_ce[i]) m_div[i] = !m_div[i];
            end else begin
                m_ce[i] = 0;
            end
        end
        if (cfg_we && int'(cfg_ch) < CH) m_inc[cfg_ch] = longint'(cfg_inc);
        if (cfg_we || cfg_sync || !run) m_since = 0;
        else m_since++;
    endtask

    task automatic check_outputs();
        logic [CH-1:0] exp_ce;
        logic [CH-1:0] exp_div;
        for (int i = 0; i < CH; i++) begin
            exp_ce[i]  = m_ce[i];
            exp_div[i] = m_div[i];
        end
        check("ce", 32'(ce), 32'(exp_ce));
        check("div_clk", 32'(div_clk), 32'(exp_div));
        check("locked", 32'(locked), 32'(m_since >= LC + 1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        int guard;
        guard = 0;
        while (ce == '0 && guard < 40) begin
            tick();
            guard++;
        end
        check("rst_ce_seen", 32'(ce != '0), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_div", 32'(div_clk), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int zeros;
        int pulses;
        int last;
        int r;

        model_reset();
        #2;
        check("reset_ce", 32'(ce), 32'd0);
        check("reset_div", 32'(div_clk), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        #10;
        rst_n = 1'b1;
        run   = 1'b1;

        for (int n = 1; n <= 40; n++) begin
            tick();
            check("t1_ce0", 32'(ce[0]), 32'(n % 2 == 0));
            check("t1_div0", 32'(div_clk[0]), 32'((n / 2) % 2));
            check("t1_locked", 32'(locked), 32'(n >= 17));
        end

        cfg_we  = 1'b1;
        cfg_ch  = 2'd1;
        cfg_inc = 16'h2000;
        tick();
        zeros = (locked == 1'b0) ? 1 : 0;
        cfg_we = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (locked == 1'b0) zeros++;
        end
        check("t3_lock_low_edges", 32'(zeros), 32'(LC + 1));

        cfg_we  = 1'b1;
        cfg_ch  = 2'd0;
        cfg_inc = 16'h4000;
        tick();
        cfg_ch  = 2'd1;
        cfg_inc = 16'h1000;
        tick();
        cfg_we = 1'b0;
        for (int n = 0; n < 7; n++) tick();
        cfg_sync = 1'b1;
        tick();
        check("t4_sync_ce", 32'(ce), 32'd0);
        check("t4_sync_div", 32'(div_clk), 32'd0);
        cfg_sync = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) check("t4_ce1_quiet", 32'(ce[1]), 32'd0);
            else check("t4_both_pulse", 32'(ce[1:0]), 32'd3);
        end

        cfg_we  = 1'b1;
        cfg_ch  = 2'd3;
        cfg_inc = 16'(($urandom % 65535) + 1);
        tick();
        cfg_we = 1'b0;
        run    = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("t5_run0_ce", 32'(ce), 32'd0);
        end
        run = 1'b1;
        for (int n = 0; n < 20; n++) tick();

        cfg_we  = 1'b1;
        cfg_ch  = 2'd2;
        cfg_inc = 16'h3873;
        tick();
        cfg_we   = 1'b0;
        cfg_sync = 1'b1;
        tick();
        cfg_sync = 1'b0;
        pulses = 0;
        last   = -1;
        for (int n = 0; n < 65536; n++) begin
            tick();
            if (ce[2]) begin
                if (last >= 0) check("t2_spacing", 32'((n - last == 4) || (n - last == 5)), 32'd1);
                last = n;
                pulses++;
            end
        end
        check("t2_pulse_count", 32'(pulses), 32'd14451);

        check("inc_for_half", inc_for(100, 50, 16), 32'h8000);
        check("inc_for_30m", inc_for(30000000, 6615142, 16), 32'h3873);

        async_reset();
        for (int n = 1; n <= 4; n++) tick();

        for (int n = 0; n < 3000; n++) begin
            run      = ($urandom % 8) != 0;
            cfg_we   = ($urandom % 6) == 0;
            cfg_ch   = 2'($urandom % 4);
            r        = int'($urandom % 4);
            cfg_inc  = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
            cfg_sync = ($urandom % 40) == 0;
            tick();
            if (n % 700 == 699) begin
                run      = 1'b1;
                cfg_we   = 1'b0;
                cfg_sync = 1'b0;
                async_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
